// File: rtl/mips_pkg.sv
// Shared MIPS constants: ALU op codes, opcode/funct encodings, issue FSM states.
package mips_pkg;

   // ALU control codes, shared with the ALU and its bench
   localparam logic [3:0] ALU_AND  = 4'b0000;
   localparam logic [3:0] ALU_OR   = 4'b0001;
   localparam logic [3:0] ALU_ADD  = 4'b0010;
   localparam logic [3:0] ALU_SLL  = 4'b0011;
   localparam logic [3:0] ALU_SLTU = 4'b0100;
   localparam logic [3:0] ALU_SUB  = 4'b0110;
   localparam logic [3:0] ALU_SLT  = 4'b0111;
   localparam logic [3:0] ALU_SRL  = 4'b1011;
   localparam logic [3:0] ALU_NOR  = 4'b1100;
   localparam logic [3:0] ALU_MUL  = 4'b1111;

   // Primary opcodes
   localparam logic [5:0] OP_RTYPE    = 6'h00;
   localparam logic [5:0] OP_BEQ      = 6'h04;
   localparam logic [5:0] OP_BNE      = 6'h05;
   localparam logic [5:0] OP_ADDI     = 6'h08;
   localparam logic [5:0] OP_ADDIU    = 6'h09;
   localparam logic [5:0] OP_SLTI     = 6'h0A;
   localparam logic [5:0] OP_SLTIU    = 6'h0B;
   localparam logic [5:0] OP_ANDI     = 6'h0C;
   localparam logic [5:0] OP_ORI      = 6'h0D;
   localparam logic [5:0] OP_SPECIAL2 = 6'h1C;
   localparam logic [5:0] OP_LW       = 6'h23;
   localparam logic [5:0] OP_SW       = 6'h2B;

   // R-type / SPECIAL2 function codes
   localparam logic [5:0] F_SLL  = 6'h00;
   localparam logic [5:0] F_SRL  = 6'h02;
   localparam logic [5:0] F_MUL  = 6'h02;
   localparam logic [5:0] F_ADD  = 6'h20;
   localparam logic [5:0] F_ADDU = 6'h21;
   localparam logic [5:0] F_SUB  = 6'h22;
   localparam logic [5:0] F_SUBU = 6'h23;
   localparam logic [5:0] F_AND  = 6'h24;
   localparam logic [5:0] F_OR   = 6'h25;
   localparam logic [5:0] F_NOR  = 6'h27;
   localparam logic [5:0] F_SLT  = 6'h2A;
   localparam logic [5:0] F_SLTU = 6'h2B;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_DONE = 2'd2
   } issue_state_t;

endpackage

// File: rtl/alu_decode.sv
// Combinational decode of a MIPS instruction into ALU operands and control.
module alu_decode
   import mips_pkg::*;
(
   input  logic [31:0] instr,
   input  logic [31:0] rs_val,
   input  logic [31:0] rt_val,
   output logic [31:0] a,
   output logic [31:0] b,
   output logic [3:0]  control,
   output logic [4:0]  shamt,
   output logic        illegal,
   output logic        is_beq,
   output logic        is_bne
);

   logic [5:0]  opcode;
   logic [5:0]  funct;
   logic [31:0] imm_sext;
   logic [31:0] imm_zext;
   // register specifiers are not needed: operand values arrive pre-read
   logic        unused_reg_fields;

   assign opcode            = instr[31:26];
   assign funct             = instr[5:0];
   assign imm_sext          = {{16{instr[15]}}, instr[15:0]};
   assign imm_zext          = {16'h0000, instr[15:0]};
   assign unused_reg_fields = ^instr[25:16];

   // Opcode/funct to operand selection and ALU code; unknown encodings flag illegal
   always_comb begin
      a       = rs_val;
      b       = rt_val;
      control = ALU_ADD;
      shamt   = 5'd0;
      illegal = 1'b0;
      is_beq  = 1'b0;
      is_bne  = 1'b0;
      case (opcode)
         OP_RTYPE: begin
            case (funct)
               F_ADD, F_ADDU: control = ALU_ADD;
               F_SUB, F_SUBU: control = ALU_SUB;
               F_AND:         control = ALU_AND;
               F_OR:          control = ALU_OR;
               F_NOR:         control = ALU_NOR;
               F_SLT:         control = ALU_SLT;
               F_SLTU:        control = ALU_SLTU;
               F_SLL: begin
                  control = ALU_SLL;
                  shamt   = instr[10:6];
               end
               F_SRL: begin
                  control = ALU_SRL;
                  shamt   = instr[10:6];
               end
               default:       illegal = 1'b1;
            endcase
         end
         OP_SPECIAL2: begin
            if (funct == F_MUL) control = ALU_MUL;
            else                illegal = 1'b1;
         end
         OP_ADDI, OP_ADDIU, OP_LW, OP_SW: begin
            b       = imm_sext;
            control = ALU_ADD;
         end
         OP_SLTI: begin
            b       = imm_sext;
            control = ALU_SLT;
         end
         OP_SLTIU: begin
            b       = imm_sext;
            control = ALU_SLTU;
         end
         OP_ANDI: begin
            b       = imm_zext;
            control = ALU_AND;
         end
         OP_ORI: begin
            b       = imm_zext;
            control = ALU_OR;
         end
         OP_BEQ: begin
            control = ALU_SUB;
            is_beq  = 1'b1;
         end
         OP_BNE: begin
            control = ALU_SUB;
            is_bne  = 1'b1;
         end
         default: illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issues one instruction to a slow combinational ALU, waits a fixed settle
// time, captures the result and returns it over a valid/ready response.
module alu_issue_ctrl
   import mips_pkg::*;
#(
   parameter int SETTLE_CYCLES = 12
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] instr,
   input  logic [31:0] rs_val,
   input  logic [31:0] rt_val,
   output logic [31:0] alu_a,
   output logic [31:0] alu_b,
   output logic [3:0]  alu_control,
   output logic [4:0]  alu_shamt,
   input  logic [31:0] alu_result,
   input  logic        alu_zero,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_result,
   output logic        out_zero,
   output logic        out_illegal,
   output logic        out_branch_taken
);

   localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);

   issue_state_t     state;
   logic [CNT_W-1:0] cnt;
   logic             beq_q;
   logic             bne_q;

   logic [31:0] dec_a;
   logic [31:0] dec_b;
   logic [3:0]  dec_control;
   logic [4:0]  dec_shamt;
   logic        dec_illegal;
   logic        dec_beq;
   logic        dec_bne;

   alu_decode u_decode (
      .instr   (instr),
      .rs_val  (rs_val),
      .rt_val  (rt_val),
      .a       (dec_a),
      .b       (dec_b),
      .control (dec_control),
      .shamt   (dec_shamt),
      .illegal (dec_illegal),
      .is_beq  (dec_beq),
      .is_bne  (dec_bne)
   );

   assign in_ready = (state == S_IDLE);

   // Issue FSM: accept, settle countdown, capture, hold response until taken.
   // out_valid trails entry into DONE by one clock so the response appears
   // SETTLE_CYCLES+1 edges after acceptance (one edge for illegal ops).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state            <= S_IDLE;
         cnt              <= '0;
         beq_q            <= 1'b0;
         bne_q            <= 1'b0;
         alu_a            <= '0;
         alu_b            <= '0;
         alu_control      <= '0;
         alu_shamt        <= '0;
         out_valid        <= 1'b0;
         out_result       <= '0;
         out_zero         <= 1'b0;
         out_illegal      <= 1'b0;
         out_branch_taken <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (in_valid) begin
                  if (dec_illegal) begin
                     // ALU inputs left untouched: nothing to compute
                     out_illegal      <= 1'b1;
                     out_result       <= '0;
                     out_zero         <= 1'b0;
                     out_branch_taken <= 1'b0;
                     state            <= S_DONE;
                  end else begin
                     alu_a       <= dec_a;
                     alu_b       <= dec_b;
                     alu_control <= dec_control;
                     alu_shamt   <= dec_shamt;
                     beq_q       <= dec_beq;
                     bne_q       <= dec_bne;
                     cnt         <= CNT_W'(SETTLE_CYCLES - 1);
                     state       <= S_WAIT;
                  end
               end
            end
            S_WAIT: begin
               if (cnt == '0) begin
                  out_result       <= alu_result;
                  out_zero         <= alu_zero;
                  out_illegal      <= 1'b0;
                  out_branch_taken <= (beq_q & alu_zero) | (bne_q & ~alu_zero);
                  state            <= S_DONE;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            S_DONE: begin
               if (out_valid && out_ready) begin
                  out_valid <= 1'b0;
                  state     <= S_IDLE;
               end else begin
                  out_valid <= 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural slow ALU.
module tb_alu_issue_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] instr = '0;
   logic [31:0] rs_val = '0;
   logic [31:0] rt_val = '0;
   logic [31:0] alu_a;
   logic [31:0] alu_b;
   logic [3:0]  alu_control;
   logic [4:0]  alu_shamt;
   logic [31:0] alu_result = 32'hDEAD_BEEF;
   logic        alu_zero = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_result;
   logic        out_zero;
   logic        out_illegal;
   logic        out_branch_taken;

   int n_tests = 0;
   int n_fail  = 0;

   alu_issue_ctrl #(.SETTLE_CYCLES(12)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .in_valid         (in_valid),
      .in_ready         (in_ready),
      .instr            (instr),
      .rs_val           (rs_val),
      .rt_val           (rt_val),
      .alu_a            (alu_a),
      .alu_b            (alu_b),
      .alu_control      (alu_control),
      .alu_shamt        (alu_shamt),
      .alu_result       (alu_result),
      .alu_zero         (alu_zero),
      .out_valid        (out_valid),
      .out_ready        (out_ready),
      .out_result       (out_result),
      .out_zero         (out_zero),
      .out_illegal      (out_illegal),
      .out_branch_taken (out_branch_taken)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] c, input logic [4:0] sh);
      case (c)
         4'b0010: return a + b;
         4'b0110: return a - b;
         4'b0011: return b << sh;
         4'b1011: return b >> sh;
         4'b0000: return a & b;
         4'b0001: return a | b;
         4'b1100: return ~(a | b);
         4'b0111: return {31'd0, $signed(a) < $signed(b)};
         4'b0100: return {31'd0, a < b};
         4'b1111: return a * b;
         default: return 32'h0;
      endcase
   endfunction

   // Slow ALU: garbage immediately after an input change, valid 110 time units later
   always @(alu_a or alu_b or alu_control or alu_shamt) begin
      alu_result = 32'hDEAD_BEEF;
      alu_zero   = 1'b0;
      #110;
      alu_result = alu_fn(alu_a, alu_b, alu_control, alu_shamt);
      alu_zero   = (alu_result == 32'h0);
   end

   // Present one request for a single clock, sampled #1 after the accepting edge
   task automatic issue(input logic [31:0] i, input logic [31:0] rs, input logic [31:0] rt);
      instr    = i;
      rs_val   = rs;
      rt_val   = rt;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   // Edges from acceptance until out_valid, bounded at 40
   task automatic wait_valid(output int lat);
      lat = 0;
      while (!out_valid && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic respond();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #12;
      n_tests++;
      if ({in_ready, out_valid, out_illegal, out_branch_taken, out_zero} !== 5'b10000) begin
         n_fail++; $display("FAIL reset_flags got %b exp 10000",
                            {in_ready, out_valid, out_illegal, out_branch_taken, out_zero});
      end
      n_tests++;
      if ({alu_a, alu_b, alu_control, alu_shamt, out_result} !== '0) begin
         n_fail++; $display("FAIL reset_regs a=%h b=%h c=%b sh=%0d r=%h", alu_a, alu_b,
                            alu_control, alu_shamt, out_result);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_add();
      int lat;
      issue(32'h0022_1820, 32'd4, 32'd1);
      n_tests++;
      if (alu_control !== 4'b0010) begin
         n_fail++; $display("FAIL add_ctl got %b exp 0010", alu_control);
      end
      wait_valid(lat);
      n_tests++;
      if (lat !== 13) begin n_fail++; $display("FAIL add_latency got %0d exp 13", lat); end
      n_tests++;
      if (out_result !== 32'd5 || out_zero !== 1'b0 || out_illegal !== 1'b0) begin
         n_fail++; $display("FAIL add_result got %h z=%b il=%b exp 00000005 z=0 il=0",
                            out_result, out_zero, out_illegal);
      end
      respond();
      n_tests++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         n_fail++; $display("FAIL add_handshake got v=%b rdy=%b exp v=0 rdy=1", out_valid, in_ready);
      end
   endtask

   task automatic test_branch();
      int lat;
      issue(32'h1022_0003, 32'd7, 32'd7);
      n_tests++;
      if (alu_control !== 4'b0110 || alu_b !== 32'd7) begin
         n_fail++; $display("FAIL beq_ops got c=%b b=%h exp c=0110 b=7", alu_control, alu_b);
      end
      wait_valid(lat);
      n_tests++;
      if (lat !== 13 || out_zero !== 1'b1 || out_branch_taken !== 1'b1) begin
         n_fail++; $display("FAIL beq_taken got lat=%0d z=%b bt=%b exp 13 1 1", lat, out_zero,
                            out_branch_taken);
      end
      respond();
      issue(32'h1422_0003, 32'd7, 32'd7);
      wait_valid(lat);
      n_tests++;
      if (out_zero !== 1'b1 || out_branch_taken !== 1'b0) begin
         n_fail++; $display("FAIL bne_taken got z=%b bt=%b exp 1 0", out_zero, out_branch_taken);
      end
      respond();
   endtask

   task automatic test_imm();
      int lat;
      issue(32'h2422_FFFF, 32'd1, 32'd99);
      n_tests++;
      if (alu_b !== 32'hFFFF_FFFF || alu_control !== 4'b0010) begin
         n_fail++; $display("FAIL addiu_ops got b=%h c=%b exp ffffffff 0010", alu_b, alu_control);
      end
      wait_valid(lat);
      n_tests++;
      if (out_result !== 32'h0 || out_zero !== 1'b1 || out_branch_taken !== 1'b0) begin
         n_fail++; $display("FAIL addiu_result got %h z=%b bt=%b exp 00000000 1 0", out_result,
                            out_zero, out_branch_taken);
      end
      respond();
      issue(32'h3422_FFFF, 32'd0, 32'd99);
      n_tests++;
      if (alu_b !== 32'h0000_FFFF || alu_control !== 4'b0001) begin
         n_fail++; $display("FAIL ori_ops got b=%h c=%b exp 0000ffff 0001", alu_b, alu_control);
      end
      wait_valid(lat);
      n_tests++;
      if (out_result !== 32'h0000_FFFF) begin
         n_fail++; $display("FAIL ori_result got %h exp 0000ffff", out_result);
      end
      respond();
   endtask

   task automatic test_shift_slt();
      int lat;
      issue(32'h0002_1900, 32'd0, 32'd1);
      n_tests++;
      if (alu_shamt !== 5'd4 || alu_control !== 4'b0011) begin
         n_fail++; $display("FAIL sll_ops got sh=%0d c=%b exp 4 0011", alu_shamt, alu_control);
      end
      wait_valid(lat);
      n_tests++;
      if (out_result !== 32'd16) begin
         n_fail++; $display("FAIL sll_result got %h exp 00000010", out_result);
      end
      respond();
      issue(32'h0022_182A, 32'hFFFF_FFFF, 32'd0);
      n_tests++;
      if (alu_shamt !== 5'd0 || alu_control !== 4'b0111) begin
         n_fail++; $display("FAIL slt_ops got sh=%0d c=%b exp 0 0111", alu_shamt, alu_control);
      end
      wait_valid(lat);
      n_tests++;
      if (out_result !== 32'd1) begin n_fail++; $display("FAIL slt_result got %h exp 1", out_result); end
      respond();
      issue(32'h0022_182B, 32'hFFFF_FFFF, 32'd0);
      wait_valid(lat);
      n_tests++;
      if (out_result !== 32'd0 || alu_control !== 4'b0100) begin
         n_fail++; $display("FAIL sltu_result got %h c=%b exp 0 0100", out_result, alu_control);
      end
      respond();
   endtask

   task automatic test_illegal();
      int lat;
      issue(32'hFC00_0000, 32'h1234_5678, 32'h9ABC_DEF0);
      wait_valid(lat);
      n_tests++;
      if (lat !== 1) begin n_fail++; $display("FAIL illegal_latency got %0d exp 1", lat); end
      n_tests++;
      if (out_illegal !== 1'b1 || out_result !== 32'h0) begin
         n_fail++; $display("FAIL illegal_flags got il=%b r=%h exp 1 0", out_illegal, out_result);
      end
      n_tests++;
      if (alu_control !== 4'b0100 || alu_a !== 32'hFFFF_FFFF || alu_b !== 32'h0) begin
         n_fail++; $display("FAIL illegal_alu_hold got c=%b a=%h b=%h exp 0100 ffffffff 0",
                            alu_control, alu_a, alu_b);
      end
      respond();
   endtask

   task automatic test_backpressure();
      int lat;
      int bad = 0;
      issue(32'h0022_1820, 32'd10, 32'd20);
      wait_valid(lat);
      in_valid = 1'b1;
      for (int k = 0; k < 5; k++) begin
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_result !== 32'd30) bad++;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      n_tests++;
      if (bad != 0) begin n_fail++; $display("FAIL backpressure_hold got %0d bad cycles exp 0", bad); end
      respond();
      n_tests++;
      if (in_ready !== 1'b1 || alu_a !== 32'd10) begin
         n_fail++; $display("FAIL backpressure_release got rdy=%b a=%h exp 1 0000000a", in_ready, alu_a);
      end
   endtask

   task automatic test_reset_mid_wait();
      int seen = 0;
      issue(32'h0022_1820, 32'd4, 32'd1);
      repeat (5) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      n_tests++;
      if ({alu_a, alu_b, alu_control, alu_shamt, out_result, out_valid, out_zero,
           out_illegal, out_branch_taken} !== '0 || in_ready !== 1'b1) begin
         n_fail++; $display("FAIL midwait_reset got a=%h c=%b v=%b rdy=%b exp zeros rdy=1",
                            alu_a, alu_control, out_valid, in_ready);
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 20; k++) begin
         @(posedge clk); #1;
         if (out_valid) seen++;
      end
      n_tests++;
      if (seen != 0 || in_ready !== 1'b1) begin
         n_fail++; $display("FAIL midwait_no_resp got %0d valid cycles rdy=%b exp 0 1", seen, in_ready);
      end
   endtask

   initial begin
      test_reset();
      test_add();
      test_branch();
      test_imm();
      test_shift_slt();
      test_illegal();
      test_backpressure();
      test_reset_mid_wait();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
